// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM microphone peripheral: sample width,
// register map offsets and status word bit positions.
package pdm_pkg;

  localparam int PCM_W = 16;

  localparam logic [7:0] REG_DATA      = 8'h0C;
  localparam logic [7:0] REG_STATUS    = 8'h10;
  localparam logic [7:0] REG_THRESHOLD = 8'h14;

  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVERFLOW  = 2;
  localparam int STAT_UNDERFLOW = 3;
  localparam int STAT_LEVEL_LSB = 8;
  localparam int STAT_LEVEL_MSB = 13;

  // Pointer width: one extra bit beyond the index so full and empty differ.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pdm_pcm_fifo_mem.sv
// Sample storage: DEPTH x PCM_W register file, one synchronous write port
// and one asynchronous read port so the FIFO head falls through.
module pdm_pcm_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int PCM_W = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [PCM_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [PCM_W-1:0] rdata
);

  logic [PCM_W-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/pdm_pcm_fifo.sv
// FWFT sample FIFO between the CIC3 decimator and the bus register file,
// with sticky overflow/underflow flags and a watermark interrupt.
module pdm_pcm_fifo #(
  parameter int DEPTH = 8,
  parameter int PCM_W = pdm_pkg::PCM_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [PCM_W-1:0]         in_pcm,
  input  logic                     in_valid,
  input  logic                     pop,
  input  logic                     flush,
  input  logic                     clr_flags,
  input  logic [$clog2(DEPTH):0]   threshold,
  output logic [PCM_W-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     irq
);

  import pdm_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);

  logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic             overflow_reg, overflow_next;
  logic             underflow_reg, underflow_next;
  logic [PW-1:0]    level_int;
  logic             empty_int, full_int;
  logic             push, pop_eff, push_ok;
  logic [PCM_W-1:0] head_data;

  assign level_int = wr_ptr_reg - rd_ptr_reg;
  assign empty_int = (level_int == '0);
  assign full_int  = (level_int == PW'(DEPTH));

  assign push    = enable & in_valid;
  assign pop_eff = pop & ~empty_int;
  // When full, a same-cycle pop frees the head slot, which is exactly the
  // slot wr_ptr addresses, so the write can land there safely.
  assign push_ok = push & (~full_int | pop_eff) & ~flush;

  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    overflow_next  = overflow_reg & ~clr_flags;
    underflow_next = underflow_reg & ~clr_flags;
    if (flush) begin
      wr_ptr_next    = '0;
      rd_ptr_next    = '0;
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_next = wr_ptr_reg + PW'(1);
      end
      if (pop_eff) begin
        rd_ptr_next = rd_ptr_reg + PW'(1);
      end
      // Flag set events win over a same-cycle clr_flags.
      if (push & full_int & ~pop_eff) begin
        overflow_next = 1'b1;
      end
      if (pop & empty_int) begin
        underflow_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  pdm_pcm_fifo_mem #(
    .DEPTH (DEPTH),
    .PCM_W (PCM_W),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr_reg[AW-1:0]),
    .wdata (in_pcm),
    .raddr (rd_ptr_reg[AW-1:0]),
    .rdata (head_data)
  );

  assign out_data  = empty_int ? '0 : head_data;
  assign level     = level_int;
  assign empty     = empty_int;
  assign full      = full_int;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;
  // Threshold above DEPTH can never be reached since level saturates at DEPTH.
  assign irq = ((threshold != '0) && (level_int >= threshold)) | overflow_reg;

endmodule

// File: tb/tb_pdm_pcm_fifo.sv
// Directed bench for pdm_pcm_fifo: a vector table for single-cycle behaviour
// plus hand-written sequences for fill/drain, overflow and watermark cases.
module tb_pdm_pcm_fifo;

  localparam int DEPTH = 8;
  localparam int PCM_W = 16;
  localparam int PW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic [PCM_W-1:0] in_pcm;
  logic             in_valid;
  logic             pop;
  logic             flush;
  logic             clr_flags;
  logic [PW-1:0]    threshold;
  logic [PCM_W-1:0] out_data;
  logic [PW-1:0]    level;
  logic             empty, full, overflow, underflow, irq;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pdm_pcm_fifo #(.DEPTH(DEPTH), .PCM_W(PCM_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .in_pcm    (in_pcm),
    .in_valid  (in_valid),
    .pop       (pop),
    .flush     (flush),
    .clr_flags (clr_flags),
    .threshold (threshold),
    .out_data  (out_data),
    .level     (level),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow),
    .irq       (irq)
  );

  typedef struct {
    logic             rst_n, en, vld;
    logic [PCM_W-1:0] din;
    logic             pop, flush, clr;
    logic [PW-1:0]    thr;
    logic [PW-1:0]    e_level;
    logic [PCM_W-1:0] e_out;
    logic             e_empty, e_full, e_ovf, e_unf, e_irq;
  } vec_t;

  localparam int NVEC = 28;
  vec_t vecs [NVEC];

  function automatic vec_t mk(
    input logic r, input logic en, input logic vld, input logic [PCM_W-1:0] din,
    input logic p, input logic fl, input logic clr, input logic [PW-1:0] thr,
    input logic [PW-1:0] lvl, input logic [PCM_W-1:0] dout,
    input logic emp, input logic ful, input logic ovf, input logic unf, input logic ir);
    vec_t v;
    v.rst_n = r;   v.en = en;      v.vld = vld;    v.din = din;
    v.pop = p;     v.flush = fl;   v.clr = clr;    v.thr = thr;
    v.e_level = lvl; v.e_out = dout; v.e_empty = emp; v.e_full = ful;
    v.e_ovf = ovf; v.e_unf = unf;  v.e_irq = ir;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic chk_all(input string tag, input logic [PW-1:0] lvl, input logic [PCM_W-1:0] dout,
                         input logic emp, input logic ful, input logic ovf, input logic unf,
                         input logic ir);
    chk({tag, ".level"},     32'(level),     32'(lvl));
    chk({tag, ".out_data"},  32'(out_data),  32'(dout));
    chk({tag, ".empty"},     32'(empty),     32'(emp));
    chk({tag, ".full"},      32'(full),      32'(ful));
    chk({tag, ".overflow"},  32'(overflow),  32'(ovf));
    chk({tag, ".underflow"}, 32'(underflow), 32'(unf));
    chk({tag, ".irq"},       32'(irq),       32'(ir));
  endtask

  // One clock transaction; strobes return to idle right after the edge.
  task automatic step(input logic r, input logic en, input logic vld, input logic [PCM_W-1:0] din,
                      input logic p, input logic fl, input logic clr);
    rst_n = r; enable = en; in_valid = vld; in_pcm = din;
    pop = p; flush = fl; clr_flags = clr;
    @(posedge clk);
    #1;
    in_valid = 1'b0; pop = 1'b0; flush = 1'b0; clr_flags = 1'b0; rst_n = 1'b1;
    $display("txn rst_n=%0b en=%0b vld=%0b din=%04h pop=%0b flush=%0b clr=%0b thr=%0d -> level=%0d out=%04h e=%0b f=%0b ovf=%0b unf=%0b irq=%0b",
             r, en, vld, din, p, fl, clr, threshold, level, out_data, empty, full, overflow,
             underflow, irq);
  endtask

  task automatic push_w(input logic [PCM_W-1:0] d);
    step(1'b1, 1'b1, 1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop_w();
    step(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; in_pcm = '0; in_valid = 1'b0;
    pop = 1'b0; flush = 1'b0; clr_flags = 1'b0; threshold = '0;

    //                rst en vld din      pop fl clr thr  lvl out      emp ful ovf unf irq
    vecs[0]  = mk(0, 0, 0, 16'h0000, 0, 0, 0, 0,   0, 16'h0000, 1, 0, 0, 0, 0);
    vecs[1]  = mk(1, 1, 1, 16'h1234, 0, 0, 0, 0,   1, 16'h1234, 0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 1, 1, 16'hBEEF, 0, 0, 0, 0,   2, 16'h1234, 0, 0, 0, 0, 0);
    vecs[3]  = mk(1, 1, 0, 16'h0000, 1, 0, 0, 0,   1, 16'hBEEF, 0, 0, 0, 0, 0);
    vecs[4]  = mk(1, 1, 0, 16'h0000, 1, 0, 0, 0,   0, 16'h0000, 1, 0, 0, 0, 0);
    vecs[5]  = mk(1, 1, 0, 16'h0000, 1, 0, 0, 0,   0, 16'h0000, 1, 0, 0, 1, 0);
    vecs[6]  = mk(1, 1, 0, 16'h0000, 1, 0, 1, 0,   0, 16'h0000, 1, 0, 0, 1, 0);
    vecs[7]  = mk(1, 1, 0, 16'h0000, 0, 0, 1, 0,   0, 16'h0000, 1, 0, 0, 0, 0);
    vecs[8]  = mk(1, 1, 1, 16'h1111, 1, 0, 0, 0,   1, 16'h1111, 0, 0, 0, 1, 0);
    vecs[9]  = mk(1, 1, 0, 16'h0000, 0, 0, 1, 0,   1, 16'h1111, 0, 0, 0, 0, 0);
    vecs[10] = mk(1, 1, 0, 16'h0000, 1, 0, 0, 0,   0, 16'h0000, 1, 0, 0, 0, 0);
    vecs[11] = mk(1, 1, 1, 16'h0001, 0, 0, 0, 4,   1, 16'h0001, 0, 0, 0, 0, 0);
    vecs[12] = mk(1, 1, 1, 16'h0002, 0, 0, 0, 4,   2, 16'h0001, 0, 0, 0, 0, 0);
    vecs[13] = mk(1, 1, 1, 16'h0003, 0, 0, 0, 4,   3, 16'h0001, 0, 0, 0, 0, 0);
    vecs[14] = mk(1, 1, 1, 16'h0004, 0, 0, 0, 4,   4, 16'h0001, 0, 0, 0, 0, 1);
    vecs[15] = mk(1, 1, 0, 16'h0000, 1, 0, 0, 4,   3, 16'h0002, 0, 0, 0, 0, 0);
    vecs[16] = mk(1, 1, 0, 16'h0000, 0, 1, 0, 4,   0, 16'h0000, 1, 0, 0, 0, 0);
    vecs[17] = mk(1, 1, 1, 16'h000A, 0, 0, 0, 0,   1, 16'h000A, 0, 0, 0, 0, 0);
    vecs[18] = mk(1, 1, 1, 16'h000B, 0, 0, 0, 0,   2, 16'h000A, 0, 0, 0, 0, 0);
    vecs[19] = mk(1, 1, 1, 16'h000C, 0, 0, 0, 0,   3, 16'h000A, 0, 0, 0, 0, 0);
    vecs[20] = mk(1, 1, 1, 16'h000D, 0, 0, 0, 0,   4, 16'h000A, 0, 0, 0, 0, 0);
    vecs[21] = mk(1, 1, 1, 16'h000E, 0, 0, 0, 0,   5, 16'h000A, 0, 0, 0, 0, 0);
    vecs[22] = mk(1, 1, 1, 16'h5555, 0, 1, 0, 0,   0, 16'h0000, 1, 0, 0, 0, 0);
    vecs[23] = mk(1, 0, 1, 16'h7777, 0, 0, 0, 0,   0, 16'h0000, 1, 0, 0, 0, 0);
    vecs[24] = mk(1, 0, 1, 16'h8888, 0, 0, 0, 0,   0, 16'h0000, 1, 0, 0, 0, 0);
    vecs[25] = mk(1, 1, 1, 16'h0101, 0, 0, 0, 0,   1, 16'h0101, 0, 0, 0, 0, 0);
    vecs[26] = mk(1, 1, 1, 16'h0202, 0, 0, 0, 0,   2, 16'h0101, 0, 0, 0, 0, 0);
    vecs[27] = mk(0, 1, 1, 16'h0303, 0, 0, 0, 0,   0, 16'h0000, 1, 0, 0, 0, 0);

    @(negedge clk);
    for (int i = 0; i < NVEC; i++) begin
      threshold = vecs[i].thr;
      step(vecs[i].rst_n, vecs[i].en, vecs[i].vld, vecs[i].din,
           vecs[i].pop, vecs[i].flush, vecs[i].clr);
      chk_all($sformatf("vec%0d", i), vecs[i].e_level, vecs[i].e_out, vecs[i].e_empty,
              vecs[i].e_full, vecs[i].e_ovf, vecs[i].e_unf, vecs[i].e_irq);
    end

    // Overfill: nine pushes, the ninth is dropped and raises overflow/irq.
    threshold = '0;
    for (int i = 0; i < 9; i++) push_w(16'(i));
    chk_all("ovf_full", 8, 16'h0000, 0, 1, 1, 0, 1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ovf_drain%0d", i), 32'(out_data), 32'(i));
      pop_w();
    end
    chk_all("ovf_drained", 0, 16'h0000, 1, 0, 1, 0, 1);
    step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk_all("ovf_cleared", 0, 16'h0000, 1, 0, 0, 0, 0);

    // Full with simultaneous push and pop: no overflow, new sample lands last.
    for (int i = 0; i < 8; i++) push_w(16'h0010 + 16'(i));
    step(1'b1, 1'b1, 1'b1, 16'hAAAA, 1'b1, 1'b0, 1'b0);
    chk_all("pp_full", 8, 16'h0011, 0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("pp_drain%0d", i), 32'(out_data),
          (i == 7) ? 32'hAAAA : 32'(16'h0011 + 16'(i)));
      pop_w();
    end
    chk_all("pp_empty", 0, 16'h0000, 1, 0, 0, 0, 0);

    // Watermark disabled at 0 and unreachable above DEPTH; combinational at 8.
    for (int i = 0; i < 8; i++) push_w(16'h0100 + 16'(i));
    chk_all("thr0_full", 8, 16'h0100, 0, 1, 0, 0, 0);
    threshold = 4'd9;
    #1 chk("thr9_irq", 32'(irq), 32'h0);
    threshold = 4'd8;
    #1 chk("thr8_irq", 32'(irq), 32'h1);
    threshold = '0;
    // Overflow event together with clr_flags: the set wins.
    step(1'b1, 1'b1, 1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b1);
    chk_all("ovf_vs_clr", 8, 16'h0100, 0, 1, 1, 0, 1);
    step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk_all("final_flush", 0, 16'h0000, 1, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
